// File: rtl/led_frame_sequencer.sv
// led_frame_sequencer
//   Holds a 24-bit {R,G,B} colour per LED and, on request, serialises a whole
//   frame (LED 0 first, GRB order, MSB first) through the bit-level line
//   driver's start/done handshake. After the last bit the line is held idle
//   for the latch interval. The frame always transmits from a shadow copy
//   taken at frame start, so colour writes never disturb a frame in flight.
//
//   Optional build macro: LED_AUTO_REFRESH_EN
//     defined   - a new frame starts automatically in the cycle after
//                 frame_done (busy drops for one cycle only); go still works.
//     undefined - frames start only on go.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   wr_en      colour write strobe
//   wr_addr    LED index to write (indices >= NUM_LEDS are ignored)
//   wr_data    colour {R[7:0],G[7:0],B[7:0]}
//   go         start-frame request, sampled only in IDLE
//   busy       high whenever the state is not IDLE
//   frame_done one-cycle pulse in the first IDLE cycle after a frame
//   bit_code   bit value presented to the line driver
//   bit_start  one-cycle start strobe to the line driver
//   bit_done   line driver free (high) / sending (low)
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for go
// LOAD    | reset indices to LED 0 / bit 23, select first bit
// ISSUE   | strobe bit_start once the driver is free
// WAIT_LO | wait for the driver to accept the bit (bit_done low)
// WAIT_HI | wait for the driver to finish, then advance or latch
// LATCH   | hold the line idle for CYCLES_RESET cycles

module led_frame_sequencer #(
  parameter int NUM_LEDS     = 8,
  parameter int ADDR_W       = 8,
  parameter int CYCLES_RESET = 20000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              go,
  output logic              busy,
  output logic              frame_done,
  output logic              bit_code,
  output logic              bit_start,
  input  logic              bit_done
);

  localparam int LED_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int CNT_W = (CYCLES_RESET > 1) ? $clog2(CYCLES_RESET) : 1;
  localparam logic [LED_W-1:0] LAST_LED  = LED_W'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0] LATCH_END = CNT_W'(CYCLES_RESET - 1);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_LO, WAIT_HI, LATCH} state_t;

  state_t           state, state_nxt;
  logic [23:0]      colour [NUM_LEDS];
  logic [23:0]      shadow [NUM_LEDS];
  logic [LED_W-1:0] led_idx, led_idx_nxt;
  logic [4:0]       bit_idx, bit_idx_nxt;
  logic [CNT_W-1:0] latch_cnt, latch_cnt_nxt;
  logic             bit_start_nxt, bit_code_nxt, frame_done_nxt;
  logic             start_frame, wr_hit, sel_bit;
  logic [23:0]      sel_colour, sel_grb;

  assign wr_hit = wr_en && (32'(wr_addr) < 32'(NUM_LEDS));
  assign busy   = (state != IDLE);

`ifdef LED_AUTO_REFRESH_EN
  // frame_done is only high in the first IDLE cycle, so it doubles as the
  // automatic restart request.
  assign start_frame = (state == IDLE) && (go || frame_done);
`else
  assign start_frame = (state == IDLE) && go;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        colour[i] <= '0;
        shadow[i] <= '0;
      end
    end else begin
      if (wr_hit)
        colour[wr_addr[LED_W-1:0]] <= wr_data;
      // Nonblocking copy: a write on the same edge lands only in colour.
      if (start_frame)
        for (int i = 0; i < NUM_LEDS; i++)
          shadow[i] <= colour[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      led_idx    <= '0;
      bit_idx    <= '0;
      latch_cnt  <= '0;
      bit_start  <= 1'b0;
      bit_code   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      led_idx    <= led_idx_nxt;
      bit_idx    <= bit_idx_nxt;
      latch_cnt  <= latch_cnt_nxt;
      bit_start  <= bit_start_nxt;
      bit_code   <= bit_code_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    led_idx_nxt    = led_idx;
    bit_idx_nxt    = bit_idx;
    latch_cnt_nxt  = latch_cnt;
    bit_start_nxt  = 1'b0;
    bit_code_nxt   = bit_code;
    frame_done_nxt = 1'b0;
    sel_bit        = 1'b0;
    sel_colour     = '0;
    sel_grb        = '0;

    case (state)
      IDLE: if (start_frame) state_nxt = LOAD;
      LOAD: begin
        led_idx_nxt = '0;
        bit_idx_nxt = 5'd23;
        sel_bit     = 1'b1;
        state_nxt   = ISSUE;
      end
      ISSUE: if (bit_done) begin
        bit_start_nxt = 1'b1;
        state_nxt     = WAIT_LO;
      end
      WAIT_LO: if (!bit_done) state_nxt = WAIT_HI;
      WAIT_HI: if (bit_done) begin
        if (led_idx == LAST_LED && bit_idx == 5'd0) begin
          latch_cnt_nxt = '0;
          state_nxt     = LATCH;
        end else begin
          if (bit_idx == 5'd0) begin
            bit_idx_nxt = 5'd23;
            led_idx_nxt = led_idx + 1'b1;
          end else begin
            bit_idx_nxt = bit_idx - 5'd1;
          end
          sel_bit   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      LATCH: begin
        if (latch_cnt == LATCH_END) begin
          frame_done_nxt = 1'b1;
          state_nxt      = IDLE;
        end else begin
          latch_cnt_nxt = latch_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // bit_code is loaded on entry to ISSUE and then held until the next bit,
    // since the driver samples it one cycle after bit_start.
    if (sel_bit) begin
      sel_colour   = shadow[led_idx_nxt];
      sel_grb      = {sel_colour[15:8], sel_colour[23:16], sel_colour[7:0]};
      bit_code_nxt = sel_grb[bit_idx_nxt];
    end
  end

endmodule

// File: doc/led_frame_sequencer.md
Name: led_frame_sequencer

Overview:
- Upstream of the bit-level LED line driver.
- Holds a 24-bit colour for each of NUM_LEDS IN-PI556FCH LEDs.
- On request, serialises all colours one bit at a time through the driver's code/start/done handshake, then holds the line idle for the latch (reset) interval.
- Sits between the AXI register slave, which writes the colours, and the line driver, which toggles the LED data pin.

Parameters:
- NUM_LEDS, 8, number of LEDs in the chain (1..256).
- ADDR_W, 8, width of wr_addr.
- CYCLES_RESET, 20000, latch interval in clk cycles after the last bit (100 us at 200 MHz).

Ports:
- clk  in  1  system clock, 200 MHz.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  colour write strobe.
- wr_addr  in  ADDR_W  LED index to write.
- wr_data  in  24  colour as {R[7:0],G[7:0],B[7:0]}.
- go  in  1  start-frame request, sampled only in IDLE.
- busy  out  1  high whenever the state is not IDLE.
- frame_done  out  1  one-cycle pulse at frame completion.
- bit_code  out  1  bit value presented to the line driver.
- bit_start  out  1  one-cycle start strobe to the line driver.
- bit_done  in  1  line driver done: high when free, low while sending.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: colour array = 0, shadow = 0, state = IDLE, bit_start = 0, bit_code = 0, frame_done = 0, busy = 0, counters = 0.
- Reset mid-frame aborts immediately. No further bit_start is issued.
- Colour array:
  - wr_en=1 with wr_addr < NUM_LEDS writes wr_data on the clock edge, in any state.
  - wr_addr >= NUM_LEDS is ignored.
- Frame start and shadow copy:
  - go=1 in IDLE copies the whole colour array into a shadow array on the same edge, then moves to LOAD.
  - A write in that same cycle does not reach the shadow; it affects the next frame.
- Frame content: the frame always transmits from the shadow, so writes during a frame never alter the frame in flight.
- Transmit order: LED 0 first. Within each LED, G7..G0, then R7..R0, then B7..B0 (MSB first, GRB order). One frame is 24*NUM_LEDS bits.
- States:
  - IDLE: go -> LOAD.
  - LOAD: led_idx=0, bit_idx=23. Select the first bit -> ISSUE.
  - ISSUE: drive bit_code; bit_start=1 for exactly one cycle -> WAIT_LO.
  - WAIT_LO: wait for bit_done==0 -> WAIT_HI.
  - WAIT_HI: wait for bit_done==1, then:
    - if the last bit of the last LED -> LATCH, latch counter cleared;
    - else advance bit_idx (at 0, wrap to 23 and increment led_idx) -> ISSUE.
  - LATCH: count to CYCLES_RESET-1. On reaching it, pulse frame_done and go to IDLE.
- bit_code hold rule: bit_code is registered and held stable from ISSUE through WAIT_HI, because the driver samples it one cycle after bit_start.
- Handshake safety: bit_start never asserts while bit_done==0. If ISSUE is entered with bit_done==0, it waits with bit_start=0.
- frame_done: registered. It is high in the first IDLE cycle; busy is 0 in that same cycle.
- go timing:
  - go in the frame_done cycle is accepted.
  - go while busy is ignored. No queueing.
- Latency: go at edge N -> bit_start high in cycle N+2.
- Bit rate: about 241 cycles per "0" bit and 241 per "1" bit, plus 3 cycles of handshake overhead per bit.

Optional Feature:
- Macro: LED_AUTO_REFRESH_EN.
- Defined: when LATCH completes, frame_done pulses and the block returns to IDLE. It then starts a new frame automatically in the next cycle, re-copying the shadow as if go=1, and busy drops for one cycle only. The go input remains functional.
- Undefined: frames start only on go.

Test Plan:
- Reset: hold rst_n=0, then release -> all outputs 0 and busy=0. No bit_start for 1000 cycles with go=0.
- Single LED, NUM_LEDS=1: write wr_data=24'hFF0081, pulse go -> 24 bit_starts with codes 0,0,0,0,0,0,0,0, 1,1,1,1,1,1,1,1, 1,0,0,0,0,0,0,1 (G, R, B). Then a CYCLES_RESET latch, then a single frame_done.
- Shadow isolation: NUM_LEDS=2, write LED1=24'h000000, go, then write LED1=24'hFFFFFF mid-frame -> LED1 bits all 0 in this frame; the next frame sends them all 1.
- Ignored events: go while busy -> no second frame. wr_addr=8 with NUM_LEDS=8 -> array unchanged.
- Abort: assert rst_n=0 during bit 10 -> bit_start=0, busy=0 immediately. A new go sends a full frame starting at LED 0, bit G7.
- With LED_AUTO_REFRESH_EN: single go -> frames repeat back to back, with frame_done every (24*NUM_LEDS bit times + CYCLES_RESET + overhead) cycles.
